// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences one pipeline load/store at a time against a word-wide data
//   memory. Sub-word loads are extracted and extended from the read word.
//   Sub-word stores do a read-modify-write. Misaligned or illegal accesses
//   complete with rsp_fault and never touch memory.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write, req_type     store/load select and funct3 access type
//   req_addr, req_wdata     byte address and right-aligned store data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata, rsp_fault    extended load data (0 for stores/faults), fault flag
//   mem_address             word-aligned memory address
//   mem_data_out            full-word write data
//   mem_data_in             combinational word read data
//   mem_enable              memory access strobe
//   mem_write_enable        memory write strobe
//   mem_type                always WORD; lane handling is done here
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_type,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_out,
  input  logic [XLEN-1:0] mem_data_in,
  output logic            mem_enable,
  output logic            mem_write_enable,
  output logic [2:0]      mem_type
);

  localparam logic [2:0] TYPE_BYTE  = 3'd0;
  localparam logic [2:0] TYPE_HALF  = 3'd1;
  localparam logic [2:0] TYPE_WORD  = 3'd2;
  localparam logic [2:0] TYPE_BYTEU = 3'd4;
  localparam logic [2:0] TYPE_HALFU = 3'd5;

  localparam logic [XLEN-1:0] BYTE_MASK = {{(XLEN-8){1'b0}}, 8'hFF};
  localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-16){1'b0}}, 16'hFFFF};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic            write_reg;
  logic [2:0]      type_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  // Holds the store word headed for memory (stores) or the extended load
  // result (loads); one register serves both since they never coexist.
  logic [XLEN-1:0] data_reg;
  logic            fault_reg;

  logic            accept;
  logic            req_fault;
  logic [4:0]      lane_shift;
  logic [XLEN-1:0] lane_word;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] merge_value;
  logic [XLEN-1:0] aligned_addr;

  assign accept       = req_valid && (state_reg == IDLE);
  assign aligned_addr = {addr_reg[XLEN-1:2], 2'b00};
  assign mem_type     = TYPE_WORD;

  // Fault classification of the incoming request.
  always_comb begin
    req_fault = 1'b0;
    case (req_type)
      TYPE_BYTE, TYPE_BYTEU: req_fault = 1'b0;
      TYPE_HALF, TYPE_HALFU: req_fault = req_addr[0];
      TYPE_WORD:             req_fault = (req_addr[1:0] != 2'b00);
      default:               req_fault = 1'b1;
    endcase
    if (req_write && (req_type == TYPE_BYTEU || req_type == TYPE_HALFU)) begin
      req_fault = 1'b1;
    end
  end

  // Lane extraction and merge. Halfword accesses are aligned by the time
  // they get here, so the byte-lane shift also selects the right halfword.
  always_comb begin
    lane_shift  = {addr_reg[1:0], 3'b000};
    lane_word   = mem_data_in >> lane_shift;
    load_value  = mem_data_in;
    merge_value = mem_data_in;
    case (type_reg)
      TYPE_BYTE:  load_value = {{(XLEN-8){lane_word[7]}}, lane_word[7:0]};
      TYPE_HALF:  load_value = {{(XLEN-16){lane_word[15]}}, lane_word[15:0]};
      TYPE_BYTEU: load_value = {{(XLEN-8){1'b0}}, lane_word[7:0]};
      TYPE_HALFU: load_value = {{(XLEN-16){1'b0}}, lane_word[15:0]};
      default:    load_value = mem_data_in;
    endcase
    if (type_reg[0]) begin
      merge_value = (mem_data_in & ~(HALF_MASK << lane_shift))
                  | ((wdata_reg & HALF_MASK) << lane_shift);
    end else begin
      merge_value = (mem_data_in & ~(BYTE_MASK << lane_shift))
                  | ((wdata_reg & BYTE_MASK) << lane_shift);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_fault)                     state_next = RESP;
          else if (!req_write)               state_next = RD;
          else if (req_type == TYPE_WORD)    state_next = WR;
          else                               state_next = RD;
        end
      end
      RD:      state_next = write_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request and data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_reg <= 1'b0;
      type_reg  <= 3'd0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      data_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      if (accept) begin
        write_reg <= req_write;
        type_reg  <= req_type;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        fault_reg <= req_fault;
        // A WORD store skips RD, so its write word is loaded straight away.
        data_reg  <= (req_write && req_type == TYPE_WORD) ? req_wdata : '0;
      end
      if (state_reg == RD) begin
        data_reg <= write_reg ? merge_value : load_value;
      end
    end
  end

  // Output logic. Memory strobes are gated by reset so a reset cycle can
  // never write, even mid-operation.
  always_comb begin
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_rdata        = '0;
    rsp_fault        = 1'b0;
    mem_address      = '0;
    mem_data_out     = '0;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      RD: begin
        mem_enable  = !reset;
        mem_address = aligned_addr;
      end
      WR: begin
        mem_enable       = !reset;
        mem_write_enable = !reset;
        mem_address      = aligned_addr;
        mem_data_out     = data_reg;
      end
      RESP: begin
        rsp_valid = !reset;
        rsp_fault = fault_reg;
        rsp_rdata = (write_reg || fault_reg) ? '0 : data_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. Expected responses are queued when a
//   request is driven and popped when rsp_valid appears; latency and the
//   memory cycles seen on the way are checked per transaction.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [2:0]  mem_type;

  load_store_unit #(.XLEN(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_type         (req_type),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_fault        (rsp_fault),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .mem_type         (mem_type)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walks cycles after an accept edge until rsp_valid, recording memory cycles.
  task automatic wait_rsp(input string tag, input int max_cycles, output int lat,
                          output int rd_n, output int wr_n, output logic [31:0] rd_addr,
                          output logic [31:0] wr_addr, output logic [31:0] wr_data);
    exp_t e;
    bit   done;
    lat = 0; rd_n = 0; wr_n = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    done = 1'b0;
    while (!done && lat < max_cycles) begin
      @(negedge clock);
      lat++;
      if (mem_enable === 1'b1) begin
        if (mem_write_enable === 1'b1) begin
          wr_n++; wr_addr = mem_address; wr_data = mem_data_out;
        end else begin
          rd_n++; rd_addr = mem_address;
        end
      end
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          check({tag, " unexpected_rsp"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, " rdata"}, rsp_rdata, e.rdata);
          check({tag, " fault"}, {31'd0, rsp_fault}, {31'd0, e.fault});
        end
      end
    end
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  // One complete request, started and ended at a falling edge.
  task automatic do_req(input string name, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                        input logic [31:0] er, input logic ef, input int el,
                        input int erd, input int ewr, input logic [31:0] ewd);
    int          lat, rdn, wrn;
    logic [31:0] rda, wra, wrd;
    check({name, " ready"}, {31'd0, req_ready}, 32'd1);
    mem_data_in = mw;
    req_valid = 1'b1; req_write = w; req_type = t; req_addr = a; req_wdata = wd;
    sb.push_back('{rdata: er, fault: ef});
    @(posedge clock);
    #1 req_valid = 1'b0;
    wait_rsp(name, 8, lat, rdn, wrn, rda, wra, wrd);
    check({name, " latency"}, lat, el);
    check({name, " rd_cycles"}, rdn, erd);
    check({name, " wr_cycles"}, wrn, ewr);
    if (erd > 0) check({name, " rd_addr"}, rda, {a[31:2], 2'b00});
    if (ewr > 0) begin
      check({name, " wr_addr"}, wra, {a[31:2], 2'b00});
      check({name, " wr_data"}, wrd, ewd);
    end
    $display("txn %s: write=%0d type=%0d addr=%h lat=%0d rd=%0d wr=%0d wdata=%h",
             name, w, t, a, lat, rdn, wrn, wrd);
    @(negedge clock);
    check({name, " pulse_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int          lat, rdn, wrn;
    logic [31:0] rda, wra, wrd;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = 3'd0;
    req_addr = '0; req_wdata = '0; mem_data_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset mem_enable", {31'd0, mem_enable}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("mem_type", {29'd0, mem_type}, 32'd2);
    reset = 1'b0;
    @(negedge clock);

    //     name            w     type  addr          wdata         memword       exp_rdata     flt  lat rd wr wr_data
    do_req("lb_neg",       1'b0, 3'd0, 32'h10000003, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0);
    do_req("sh_merge",     1'b1, 3'd1, 32'h10000006, 32'h0000ABCD, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'hABCD3344);
    do_req("lw_misalign",  1'b0, 3'd2, 32'h10000002, 32'h0,        32'h55555555, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    do_req("sbu_illegal",  1'b1, 3'd4, 32'h40000000, 32'h000000AA, 32'h55555555, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    do_req("lbu_lane2",    1'b0, 3'd4, 32'h10000002, 32'h0,        32'h80FF1234, 32'h000000FF, 1'b0, 2, 1, 0, 32'h0);
    do_req("lh_upper",     1'b0, 3'd1, 32'h10000002, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0);
    do_req("lhu_lower",    1'b0, 3'd5, 32'h10000000, 32'h0,        32'h80FF9234, 32'h00009234, 1'b0, 2, 1, 0, 32'h0);
    do_req("lw_ok",        1'b0, 3'd2, 32'h10000004, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0);
    do_req("sb_lane1",     1'b1, 3'd0, 32'h10000001, 32'hFFFFFF5A, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'h11225A44);
    do_req("sw_ok",        1'b1, 3'd2, 32'h10000008, 32'hCAFEF00D, 32'h11223344, 32'h0,        1'b0, 2, 0, 1, 32'hCAFEF00D);
    do_req("lh_misalign",  1'b0, 3'd1, 32'h10000001, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    do_req("type3",        1'b0, 3'd3, 32'h10000000, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    do_req("type7_store",  1'b1, 3'd7, 32'h10000000, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    do_req("sh_misalign",  1'b1, 3'd1, 32'h10000003, 32'h1234,     32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0);
    do_req("shu_illegal",  1'b1, 3'd5, 32'h10000000, 32'h1234,     32'h11223344, 32'h0,        1'b1, 1, 0, 0, 32'h0);

    // Reset landing in the WR cycle of a sub-word store.
    mem_data_in = 32'h11223344;
    req_valid = 1'b1; req_write = 1'b1; req_type = 3'd0; req_addr = 32'h00000020; req_wdata = 32'h77;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rst_abort rd_strobe", {31'd0, mem_enable}, 32'd1);
    @(negedge clock);
    check("rst_abort wr_before", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_abort wr_gated", {31'd0, mem_write_enable}, 32'd0);
    check("rst_abort en_gated", {31'd0, mem_enable}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("rst_abort ready", {31'd0, req_ready}, 32'd1);
    check("rst_abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_abort no_rsp", {31'd0, rsp_valid}, 32'd0);
    $display("txn rst_abort: reset in WR cycle");

    // req_valid held high across a load and a WORD store.
    mem_data_in = 32'h0BADF00D;
    req_valid = 1'b1; req_write = 1'b0; req_type = 3'd2; req_addr = 32'h00000100; req_wdata = '0;
    sb.push_back('{rdata: 32'h0BADF00D, fault: 1'b0});
    sb.push_back('{rdata: 32'h0, fault: 1'b0});
    @(posedge clock);
    #1;
    req_write = 1'b1; req_addr = 32'h00000104; req_wdata = 32'h12345678;
    check("b2b busy", {31'd0, req_ready}, 32'd0);
    wait_rsp("b2b_load", 8, lat, rdn, wrn, rda, wra, wrd);
    check("b2b_load latency", lat, 2);
    check("b2b_load wr_cycles", wrn, 0);
    @(negedge clock);
    check("b2b idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    wait_rsp("b2b_store", 8, lat, rdn, wrn, rda, wra, wrd);
    check("b2b_store latency", lat, 2);
    check("b2b_store wr_cycles", wrn, 1);
    check("b2b_store wr_addr", wra, 32'h00000104);
    check("b2b_store wr_data", wrd, 32'h12345678);
    $display("txn b2b: load then store WORD, store lat=%0d", lat);
    @(negedge clock);
    check("queue empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline access request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_type  input  3  funct3 access type: 0 BYTE, 1 HALF_WORD, 2 WORD, 4 BYTEU, 5 HALF_WORDU.
REQ-008 SHALL have port req_addr  input  XLEN  byte address.
REQ-009 SHALL have port req_wdata  input  XLEN  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  XLEN  extended load result; 0 for stores and faults.
REQ-012 SHALL have port rsp_fault  output  1  misaligned or illegal access, valid with rsp_valid.
REQ-013 SHALL have port mem_address  output  XLEN  word-aligned address to data memory.
REQ-014 SHALL have port mem_data_out  output  XLEN  full-word write data to memory.
REQ-015 SHALL have port mem_data_in  input  XLEN  combinational word read data from memory.
REQ-016 SHALL have port mem_enable  output  1  memory access strobe.
REQ-017 SHALL have port mem_write_enable  output  1  memory write strobe.
REQ-018 SHALL have port mem_type  output  3  constant 2 (WORD); all lane handling is internal.

Function
REQ-019 SHALL implement states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept on a rising edge with req_valid & req_ready, latching write, type, addr, wdata.
REQ-021 SHALL classify as fault: HALF types with addr[0]=1; WORD with addr[1:0]≠0; type 3/6/7; store with type 4/5.
REQ-022 SHALL transition: fault -> RESP; load -> RD -> RESP; WORD store -> WR -> RESP; BYTE/HALF store -> RD -> WR -> RESP; RESP -> IDLE.
REQ-023 SHALL drive in RD: mem_enable=1, mem_write_enable=0, mem_address={addr[XLEN-1:2],2'b00}; capture mem_data_in at the end-of-RD edge.
REQ-024 SHALL drive in WR: mem_enable=1, mem_write_enable=1, same aligned address, mem_data_out = merged word, for exactly one cycle.
REQ-025 SHALL merge by replacing byte lane addr[1:0] (BYTE) or halfword lane addr[1] (HALF) of the captured word with wdata[7:0]/wdata[15:0]; WORD store writes wdata unchanged.
REQ-026 SHALL extract loads from lane addr[1:0]: BYTE/HALF sign-extend, BYTEU/HALF_WORDU zero-extend, WORD passes through.
REQ-027 SHALL drive mem_enable, mem_write_enable, mem_address and mem_data_out to 0 in IDLE and RESP; a faulted request SHALL issue no memory cycle.
REQ-028 SHALL assert rsp_valid only in RESP, for one cycle, holding rsp_rdata/rsp_fault stable there.
REQ-029 SHALL give latency from accept edge to rsp_valid: fault 1 cycle, load 2, WORD store 2, sub-word store 3.
REQ-030 SHALL ignore req_valid outside IDLE; back-to-back requests are accepted in the IDLE cycle following RESP.

Reset
REQ-031 SHALL, with reset high at an edge, enter IDLE and clear all latched request/data registers.
REQ-032 SHALL gate mem_enable and mem_write_enable combinationally with !reset, so no write occurs in a reset cycle.
REQ-033 SHALL, on reset mid-operation, abort without rsp_valid; reset values: req_ready=1, all other outputs 0.

Verification
REQ-034 SHALL pass: load BYTE @0x10000003, mem word 0x80FF1234 -> RD addr 0x10000000, rsp_rdata 0xFFFFFF80 two cycles after accept.
REQ-035 SHALL pass: store HALF 0x0000ABCD @0x10000006, mem word 0x11223344 -> RD then WR addr 0x10000004, data 0xABCD3344, rsp_valid at cycle 3.
REQ-036 SHALL pass: load WORD @0x10000002 -> rsp_fault=1, rsp_rdata=0, rsp_valid at cycle 1, mem_enable never high.
REQ-037 SHALL pass: store BYTEU @0x40000000 -> fault, no memory cycle.
REQ-038 SHALL pass: reset asserted in the WR cycle of a sub-word store -> mem_write_enable 0, no rsp_valid, req_ready=1 next cycle.
REQ-039 SHALL pass: req_valid held high across load then store WORD -> second request accepted only in the IDLE cycle after the first RESP.
